turn_switch_conditioner: RTL
============================

TURN_SWITCH_CONDITIONER -- requirements
Module: turn_switch_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive mismatching cycles needed to accept a new level; legal range 2..255.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic rising-edge triggered.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port left_raw, input, 1, asynchronous bouncy left lever contact.
REQ-005 SHALL have port right_raw, input, 1, asynchronous bouncy right lever contact.
REQ-006 SHALL have port hazard_raw, input, 1, asynchronous bouncy hazard switch.
REQ-007 SHALL have port left, output, 1, registered left request to the downstream turn-signal FSM.
REQ-008 SHALL have port right, output, 1, registered right request to the downstream turn-signal FSM.
REQ-009 SHALL have port conflict, output, 1, registered flag: left and right levers both active without hazard.

Function
REQ-010 SHALL pass each raw input through a 2-flop synchronizer before any other use.
REQ-011 SHALL debounce each synchronized input: counter increments on every edge where synchronized value differs from accepted level, clears on any edge where they match.
REQ-012 SHALL update the accepted level on the edge where a mismatch is seen and the counter equals DEBOUNCE_CYCLES-1, then clear the counter.
REQ-013 SHALL, for a clean raw step first sampled at edge k, change the accepted level at edge k+DEBOUNCE_CYCLES+1 and the outputs at edge k+DEBOUNCE_CYCLES+2.
REQ-014 SHALL ignore any glitch shorter than DEBOUNCE_CYCLES synchronized cycles; accepted level and outputs unchanged.
REQ-015 SHALL implement a state machine with states IDLE, LEFT, RIGHT, HAZ, GAP, CONFLICT, evaluated on debounced levels l, r, h.
REQ-016 SHALL compute target: h=1 -> HAZ (highest priority); else l&r -> CONFLICT; else l -> LEFT; else r -> RIGHT; else IDLE.
REQ-017 SHALL, from IDLE, move directly to the target.
REQ-018 SHALL, from LEFT, RIGHT or HAZ, move to IDLE or CONFLICT directly when that is the target, and move to GAP for exactly one cycle when the target is a different one of LEFT/RIGHT/HAZ (break-before-make).
REQ-019 SHALL, from GAP, move to the target as re-evaluated in that cycle.
REQ-020 SHALL, from CONFLICT, move to HAZ if h=1, to IDLE only when l=0 and r=0, else remain in CONFLICT (a single released lever does not resume signalling).
REQ-021 SHALL drive left=1 in LEFT or HAZ, right=1 in RIGHT or HAZ, conflict=1 in CONFLICT only; all outputs 0 in IDLE and GAP; outputs are flops, not decoded combinationally from inputs.

Reset
REQ-022 SHALL, while reset=1 at an edge, force state to IDLE, left=right=conflict=0, all synchronizer flops, accepted levels and debounce counters to 0.
REQ-023 SHALL, on reset asserted mid-operation (any state, any counter value), take effect on that edge with no partial transition.
REQ-024 SHALL, after reset release with raw inputs held high, treat them as new mismatches and follow REQ-013 timing from the first post-reset edge.

Structure
REQ-025 SHALL place the state enum (IDLE, LEFT, RIGHT, HAZ, GAP, CONFLICT) and the DEBOUNCE_CYCLES default constant in shared package turn_cond_pkg.
REQ-026 SHALL implement synchronizer plus debounce as one sub-module debounce_sync, instantiated three times; counter width $clog2(DEBOUNCE_CYCLES).

Verification (DEBOUNCE_CYCLES=4, 10 ns clock)
REQ-027 SHALL verify: reset held 4 cycles, all raw 0, then released -> left=right=conflict=0 throughout.
REQ-028 SHALL verify: left_raw 0->1 sampled at edge k, held -> left=1 from edge k+6, right=0; 3-cycle left_raw pulse -> left stays 0.
REQ-029 SHALL verify: LEFT active, left_raw->0 and right_raw->1 same cycle -> left falls, exactly one cycle with left=right=0 (GAP) only if right accepted before IDLE reached, then right=1.
REQ-030 SHALL verify: left_raw=right_raw=1 stable -> conflict=1, left=right=0; release right only -> conflict stays 1; release left -> IDLE.
REQ-031 SHALL verify: RIGHT active, hazard_raw->1 -> one GAP cycle then left=right=1; hazard_raw->0 with right_raw still 1 -> GAP then right=1.
REQ-032 SHALL verify: reset asserted during HAZ with debounce counters mid-count -> next edge all outputs 0, no output change for 6 edges after release with raw inputs 0.

Source files
------------

// File: rtl/turn_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module : turn_cond_pkg
// Brief  : Shared state encoding, default debounce depth and target-selection
//          helper for the turn-switch conditioner.
// Rev    : 1.0 - initial release
// ============================================================================
package turn_cond_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LEFT     = 3'd1,
        RIGHT    = 3'd2,
        HAZ      = 3'd3,
        GAP      = 3'd4,
        CONFLICT = 3'd5
    } turn_state_t;

    // Hazard dominates; two levers without hazard are a driver error.
    function automatic turn_state_t target_state(input logic l, input logic r, input logic h);
        turn_state_t t;
        if (h)
            t = HAZ;
        else if (l && r)
            t = CONFLICT;
        else if (l)
            t = LEFT;
        else if (r)
            t = RIGHT;
        else
            t = IDLE;
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/debounce_sync.sv
`default_nettype none
// ============================================================================
// Module : debounce_sync
// Brief  : Two-flop synchronizer followed by a consecutive-mismatch debouncer.
// Rev    : 1.0 - initial release
// ============================================================================
module debounce_sync
    import turn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic i_raw,
    output logic o_level
);

    localparam int                 c_CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_param_check
        $error("debounce_sync: DEBOUNCE_CYCLES must be in 2..255");
    end

    logic               r_sync1;
    logic               r_sync2;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
        end
    end

    // The counter only ever runs while the synchronized value disagrees with
    // the accepted level, so reaching its maximum means a full stable run.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else if (r_sync2 == r_level) begin
            r_cnt <= '0;
        end else if (r_cnt == c_CNT_MAX) begin
            r_cnt   <= '0;
            r_level <= r_sync2;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_level = r_level;

endmodule
`default_nettype wire

// File: rtl/turn_switch_conditioner.sv
`default_nettype none
// ============================================================================
// Module : turn_switch_conditioner
// Brief  : Debounces lever/hazard contacts and arbitrates them into
//          break-before-make left/right requests plus a conflict flag.
// Rev    : 1.0 - initial release
// ============================================================================
module turn_switch_conditioner
    import turn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic left_raw,
    input  logic right_raw,
    input  logic hazard_raw,
    output logic left,
    output logic right,
    output logic conflict
);

    logic        w_l;
    logic        w_r;
    logic        w_h;
    turn_state_t w_target;
    turn_state_t w_next;
    turn_state_t r_state;
    logic        r_left;
    logic        r_right;
    logic        r_conflict;

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_left (
        .clk     (clk),
        .rst     (reset),
        .i_raw   (left_raw),
        .o_level (w_l)
    );

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_right (
        .clk     (clk),
        .rst     (reset),
        .i_raw   (right_raw),
        .o_level (w_r)
    );

    debounce_sync #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_hazard (
        .clk     (clk),
        .rst     (reset),
        .i_raw   (hazard_raw),
        .o_level (w_h)
    );

    assign w_target = target_state(w_l, w_r, w_h);

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: w_next = w_target;
            LEFT, RIGHT, HAZ: begin
                // Switching between two active patterns goes dark for one cycle.
                if (w_target == IDLE || w_target == CONFLICT)
                    w_next = w_target;
                else if (w_target != r_state)
                    w_next = GAP;
            end
            GAP: w_next = w_target;
            CONFLICT: begin
                if (w_h)
                    w_next = HAZ;
                else if (!w_l && !w_r)
                    w_next = IDLE;
                else
                    w_next = CONFLICT;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_left     <= 1'b0;
            r_right    <= 1'b0;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_left     <= (w_next == LEFT)  || (w_next == HAZ);
            r_right    <= (w_next == RIGHT) || (w_next == HAZ);
            r_conflict <= (w_next == CONFLICT);
        end
    end

    assign left     = r_left;
    assign right    = r_right;
    assign conflict = r_conflict;

endmodule
`default_nettype wire
